mod12_ctrl: RTL
===============

MOD12_CTRL -- requirements
Module: mod12_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port req  input  2  request per requester (bit 0 = R0, bit 1 = R1); held high until granted.
REQ-004 SHALL have ports data0, data1  input  4 each  load value per requester.
REQ-005 SHALL have ports mode0, mode1  input  1 each  count direction per requester (1 = up, 0 = down).
REQ-006 SHALL have ports len0, len1  input  4 each  run length in count cycles (0..15) per requester.
REQ-007 SHALL have port gnt  output  2  one-hot, one-cycle grant pulse.
REQ-008 SHALL have port done  output  2  one-hot, one-cycle completion pulse to the owning requester.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have ports cnt_load (output 1), cnt_mode (output 1), cnt_data (output 4)  drive the mod-12 counter's load, mode and data_in.
REQ-011 SHALL have port cnt_dout  input  4  mod-12 counter output.
REQ-012 SHALL have port err  output  1  sticky end-value mismatch flag (present only with MOD12_CTRL_CHECK_EN).

Function
REQ-013 SHALL implement the FSM states IDLE, LOAD, RUN and DONE.
REQ-014 IDLE SHALL do the following when req != 0: pulse gnt for the winner, latch its data/mode/len, and go to LOAD next cycle.
REQ-015 Arbitration SHALL be round-robin; priority pointer resets to R0; when both requests are high, the pointer holder wins.
REQ-016 The pointer SHALL move to the non-owner on the DONE cycle only.
REQ-017 The latched load value SHALL be clamped to 11 when greater than 11.
REQ-018 LOAD SHALL last exactly 1 cycle with cnt_load=1, cnt_data=latched value and cnt_mode=latched mode; the next state is RUN, or DONE when len=0.
REQ-019 RUN SHALL last exactly len cycles with cnt_load=0 and cnt_mode held; a down-counter runs from len-1 and the FSM exits to DONE when it reaches 0.
REQ-020 DONE SHALL last 1 cycle with done[owner]=1, then return to IDLE.
REQ-021 Grant-to-done latency SHALL be len+2 cycles after the gnt cycle.
REQ-022 Requests arriving while busy=1 SHALL be ignored (not queued); the requester keeps req high.
REQ-023 A requester whose req drops before grant SHALL be skipped with no grant.
REQ-024 Outside LOAD, cnt_load SHALL be 0; cnt_mode and cnt_data SHALL hold their last driven values.
REQ-025 gnt and done SHALL never both be nonzero in the same cycle, and each SHALL never have more than one bit set.

Reset
REQ-026 While rst=1, outputs SHALL be gnt=00, done=00, busy=0, cnt_load=0, cnt_mode=0, cnt_data=0 and err=0, with state IDLE, pointer=R0 and the run counter at 0.
REQ-027 Reset asserted mid-LOAD or mid-RUN SHALL abort the job with no done pulse; the job is lost.
REQ-028 After rst deasserts, the first grant SHALL be issued no earlier than the first rising edge with rst=0 and req!=0.

Configuration
REQ-029 Macro MOD12_CTRL_CHECK_EN SHALL be defined to compile the end-value checker in.
REQ-030 With the checker, the DONE cycle SHALL compare cnt_dout against expected = (data + len) mod 12 when up, or (data - len) mod 12 when down (modular, 0..11); a mismatch SHALL set err, which holds until rst.
REQ-031 Without the macro, err SHALL be tied to 0 and no checker logic SHALL be present; all other behaviour is identical.

Verification
REQ-032 After reset, assert req=01 with data0=3, mode0=1, len0=4 -> gnt=01 in cycle 1, cnt_load=1 with cnt_data=3 in cycle 2, done=01 in cycle 7, and cnt_dout=7 in the DONE cycle.
REQ-033 Assert req=11 in IDLE after reset -> gnt=01 first; after that done, gnt=10; issue a third R0+R1 contention -> R0 wins.
REQ-034 Load value data1=14, mode1=0, len1=2 -> cnt_data=11 during LOAD and cnt_dout=9 at DONE; err stays 0.
REQ-035 len0=0 -> LOAD then DONE immediately, done 2 cycles after gnt, and cnt_load pulses exactly once.
REQ-036 Assert rst for 1 cycle during RUN (len=10) -> all outputs reach their reset values immediately, no done pulse, busy=0, and the next request from R0 is granted.
REQ-037 With MOD12_CTRL_CHECK_EN defined, force cnt_dout wrong at DONE -> err=1 and it remains 1 until rst; without the macro, err=0.

Source files
------------

// File: rtl/mod12_ctrl.sv
// Round-robin job controller for two requesters sharing an external mod-12 counter.
// Define MOD12_CTRL_CHECK_EN to build in the sticky end-value checker on err.
module mod12_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    input  logic       mode0,
    input  logic       mode1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic       cnt_load,
    output logic       cnt_mode,
    output logic [3:0] cnt_data,
    input  logic [3:0] cnt_dout,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state;
    logic       ptr;
    logic       owner;
    logic [3:0] l_data;
    logic [3:0] l_len;
    logic       l_mode;
    logic [3:0] rcnt;

    logic       win;
    logic [3:0] w_data;
    logic [3:0] w_clamp;

    // R1 wins only if R0 is absent or R1 holds the priority pointer
    always_comb begin
        win     = req[1] & (~req[0] | ptr);
        w_data  = win ? data1 : data0;
        w_clamp = (w_data > 4'd11) ? 4'd11 : w_data;
    end

    // outputs are registered, so the state register leads the visible phase by a cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            owner    <= 1'b0;
            l_data   <= '0;
            l_len    <= '0;
            l_mode   <= 1'b0;
            rcnt     <= '0;
            gnt      <= '0;
            done     <= '0;
            busy     <= 1'b0;
            cnt_load <= 1'b0;
            cnt_mode <= 1'b0;
            cnt_data <= '0;
        end else begin
            gnt      <= '0;
            done     <= '0;
            cnt_load <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt    <= win ? 2'b10 : 2'b01;
                        owner  <= win;
                        l_data <= w_clamp;
                        l_mode <= win ? mode1 : mode0;
                        l_len  <= win ? len1 : len0;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    cnt_load <= 1'b1;
                    cnt_data <= l_data;
                    cnt_mode <= l_mode;
                    if (l_len == 4'd0) begin
                        state <= DONE;
                    end else begin
                        rcnt  <= l_len - 4'd1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rcnt == 4'd0) state <= DONE;
                    else rcnt <= rcnt - 4'd1;
                end
                DONE: begin
                    done  <= owner ? 2'b10 : 2'b01;
                    ptr   <= ~owner;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MOD12_CTRL_CHECK_EN
    logic [5:0] sum;
    logic [3:0] exp_val;

    // bias by 24 keeps the down case non-negative before the modulo
    always_comb begin
        if (l_mode) sum = {2'b00, l_data} + {2'b00, l_len};
        else sum = {2'b00, l_data} + 6'd24 - {2'b00, l_len};
        exp_val = 4'(sum % 6'd12);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else if (done != 2'b00 && cnt_dout != exp_val) err <= 1'b1;
    end
`else
    logic unused_dout;
    assign unused_dout = ^cnt_dout;
    assign err = 1'b0;
`endif

endmodule
